// File: rtl/prod_accumulator.sv
// ============================================================================
// prod_accumulator : sums LEN signed products per block with saturation
// Rev 1.0
// ============================================================================
`default_nettype none

module prod_accumulator #(
  parameter int TAM   = 16,
  parameter int GUARD = 8,
  parameter int LEN   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [2*TAM-1:0]       p_in,
  input  logic                          p_valid,
  output logic                          p_ready,
  input  logic                          clear,
  output logic signed [2*TAM+GUARD-1:0] acc_out,
  output logic                          acc_valid,
  input  logic                          acc_ready,
  output logic                          ovf,
  output logic [7:0]                    count
);

  localparam int ACCW = 2*TAM + GUARD;
  localparam logic [7:0] c_last = 8'(LEN - 1);
  localparam logic [ACCW-1:0] c_max = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] c_min = {1'b1, {(ACCW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ACCW-1:0] r_sum;
  logic [7:0]      r_count;
  logic            r_ovf;

  logic            w_accept;
  logic            w_handshake;
  logic [ACCW:0]   w_sum_wide;
  logic            w_pos_ovf;
  logic            w_neg_ovf;
  logic [ACCW-1:0] w_sum_sat;

  assign p_ready     = (r_state != HOLD);
  assign acc_valid   = (r_state == HOLD);
  assign w_accept    = p_valid && p_ready;
  assign w_handshake = acc_valid && acc_ready;

  // One extra bit makes the out-of-range result visible in the top two bits.
  assign w_sum_wide = {r_sum[ACCW-1], r_sum} + {{(GUARD+1){p_in[2*TAM-1]}}, p_in};
  assign w_pos_ovf  = ~w_sum_wide[ACCW] &  w_sum_wide[ACCW-1];
  assign w_neg_ovf  =  w_sum_wide[ACCW] & ~w_sum_wide[ACCW-1];

  always_comb begin
    w_sum_sat = w_sum_wide[ACCW-1:0];
    if (w_pos_ovf) begin
      w_sum_sat = c_max;
    end else if (w_neg_ovf) begin
      w_sum_sat = c_min;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_next = ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept && (r_count == c_last)) begin
            w_state_next = HOLD;
          end
        end
        HOLD: begin
          if (w_handshake) begin
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // clear outranks both the handshake and a simultaneous accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clear || w_handshake) begin
      r_sum   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_sum   <= w_sum_sat;
      r_count <= r_count + 8'd1;
      if (w_pos_ovf || w_neg_ovf) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign acc_out = r_sum;
  assign ovf     = r_ovf;
  assign count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_prod_accumulator.sv
// ============================================================================
// tb_prod_accumulator : directed self-checking bench for prod_accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prod_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: TAM=16, GUARD=8, LEN=8 -> 40-bit accumulator
  logic signed [31:0] p_in = '0;
  logic               p_valid = 1'b0;
  logic               p_ready;
  logic               clear = 1'b0;
  logic signed [39:0] acc_out;
  logic               acc_valid;
  logic               acc_ready = 1'b1;
  logic               ovf;
  logic [7:0]         count;

  // GUARD=1 instance -> 33-bit accumulator
  logic signed [31:0] p_in1 = '0;
  logic               p_valid1 = 1'b0;
  logic               p_ready1;
  logic               clear1 = 1'b0;
  logic signed [32:0] acc_out1;
  logic               acc_valid1;
  logic               acc_ready1 = 1'b1;
  logic               ovf1;
  logic [7:0]         count1;

  int n_cmp = 0;
  int n_bad = 0;

  prod_accumulator dut (
    .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready),
    .clear(clear), .acc_out(acc_out), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .ovf(ovf), .count(count)
  );

  prod_accumulator #(.TAM(16), .GUARD(1), .LEN(8)) dut_g1 (
    .clk(clk), .rst(rst), .p_in(p_in1), .p_valid(p_valid1), .p_ready(p_ready1),
    .clear(clear1), .acc_out(acc_out1), .acc_valid(acc_valid1),
    .acc_ready(acc_ready1), .ovf(ovf1), .count(count1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (acc_out !== 40'd0) begin n_bad++; $display("FAIL reset_acc_out got %h want 0", acc_out); end
    n_cmp++; if (acc_valid !== 1'b0) begin n_bad++; $display("FAIL reset_acc_valid got %b want 0", acc_valid); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (p_ready !== 1'b1) begin n_bad++; $display("FAIL reset_p_ready got %b want 1", p_ready); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic_sum();
    acc_ready = 1'b1;
    p_in = 32'sd1;
    p_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_cmp++; if (acc_out !== 40'd7 || count !== 8'd7) begin n_bad++; $display("FAIL basic_running got sum=%0d cnt=%0d want 7/7", acc_out, count); end
    n_cmp++; if (acc_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_early got %b want 0", acc_valid); end
    tick();
    p_valid = 1'b0;
    n_cmp++; if (acc_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", acc_valid); end
    n_cmp++; if (acc_out !== 40'd8) begin n_bad++; $display("FAIL basic_acc_out got %0d want 8", acc_out); end
    n_cmp++; if (count !== 8'd8 || ovf !== 1'b0) begin n_bad++; $display("FAIL basic_cnt_ovf got %0d/%b want 8/0", count, ovf); end
    n_cmp++; if (p_ready !== 1'b0) begin n_bad++; $display("FAIL basic_p_ready got %b want 0", p_ready); end
    tick();
    n_cmp++; if (acc_valid !== 1'b0 || count !== 8'd0 || acc_out !== 40'd0) begin
      n_bad++; $display("FAIL basic_after_hs got v=%b cnt=%0d sum=%0d want 0/0/0", acc_valid, count, acc_out);
    end
  endtask

  task automatic test_negative();
    p_in = -32'sd1;
    p_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    p_valid = 1'b0;
    n_cmp++; if (acc_out !== 40'hFFFFFFFFF8) begin n_bad++; $display("FAIL neg_acc_out got %h want FFFFFFFFF8", acc_out); end
    n_cmp++; if (ovf !== 1'b0 || acc_valid !== 1'b1) begin n_bad++; $display("FAIL neg_flags got ovf=%b v=%b want 0/1", ovf, acc_valid); end
    tick();
  endtask

  task automatic test_saturation();
    p_in1 = 32'sh7FFFFFFF;
    p_valid1 = 1'b1;
    acc_ready1 = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    p_valid1 = 1'b0;
    n_cmp++; if (acc_out1 !== 33'h0FFFFFFFF) begin n_bad++; $display("FAIL sat_pos_acc_out got %h want 0FFFFFFFF", acc_out1); end
    n_cmp++; if (ovf1 !== 1'b1 || acc_valid1 !== 1'b1 || count1 !== 8'd8) begin
      n_bad++; $display("FAIL sat_pos_flags got ovf=%b v=%b cnt=%0d want 1/1/8", ovf1, acc_valid1, count1);
    end
    tick();
    p_in1 = 32'sd5;
    p_valid1 = 1'b1;
    tick();
    p_valid1 = 1'b0;
    n_cmp++; if (ovf1 !== 1'b0 || acc_out1 !== 33'd5 || count1 !== 8'd1) begin
      n_bad++; $display("FAIL sat_next_block got ovf=%b sum=%h cnt=%0d want 0/5/1", ovf1, acc_out1, count1);
    end
    clear1 = 1'b1;
    tick();
    clear1 = 1'b0;
    // Negative clamp: -2^31 twice reaches -2^32 exactly, the third clamps.
    p_in1 = 32'sh80000000;
    p_valid1 = 1'b1;
    tick(); tick();
    n_cmp++; if (acc_out1 !== 33'h100000000 || ovf1 !== 1'b0) begin n_bad++; $display("FAIL sat_neg_exact got %h ovf=%b want 100000000/0", acc_out1, ovf1); end
    tick();
    n_cmp++; if (acc_out1 !== 33'h100000000 || ovf1 !== 1'b1) begin n_bad++; $display("FAIL sat_neg_clamp got %h ovf=%b want 100000000/1", acc_out1, ovf1); end
    for (int i = 0; i < 5; i++) tick();
    p_valid1 = 1'b0;
    tick();
    // After a positive clamp, a negative product subtracts from the clamped value.
    p_in1 = 32'sh7FFFFFFF;
    p_valid1 = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    p_in1 = 32'sh80000000;
    tick();
    p_valid1 = 1'b0;
    n_cmp++; if (acc_out1 !== 33'h07FFFFFFF || ovf1 !== 1'b1) begin n_bad++; $display("FAIL sat_continue got %h ovf=%b want 07FFFFFFF/1", acc_out1, ovf1); end
    tick();
  endtask

  task automatic test_backpressure();
    acc_ready = 1'b0;
    p_in = 32'sd2;
    p_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    p_in = 32'sd100;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (acc_out !== 40'd16 || acc_valid !== 1'b1 || count !== 8'd8 || p_ready !== 1'b0) begin
        n_bad++; $display("FAIL hold_stable[%0d] got sum=%0d v=%b cnt=%0d rdy=%b want 16/1/8/0", i, acc_out, acc_valid, count, p_ready);
      end
      tick();
    end
    n_cmp++; if (acc_out !== 40'd16 || count !== 8'd8) begin n_bad++; $display("FAIL hold_final got sum=%0d cnt=%0d want 16/8", acc_out, count); end
    p_valid = 1'b0;
    acc_ready = 1'b1;
    tick();
    n_cmp++; if (acc_valid !== 1'b0 || p_ready !== 1'b1 || count !== 8'd0 || acc_out !== 40'd0) begin
      n_bad++; $display("FAIL hold_release got v=%b rdy=%b cnt=%0d sum=%0d want 0/1/0/0", acc_valid, p_ready, count, acc_out);
    end
  endtask

  task automatic test_clear();
    p_in = 32'sd5;
    p_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (count !== 8'd3 || acc_out !== 40'd15) begin n_bad++; $display("FAIL clear_pre got cnt=%0d sum=%0d want 3/15", count, acc_out); end
    clear = 1'b1;
    p_in = 32'sd7;
    tick();
    clear = 1'b0;
    p_valid = 1'b0;
    n_cmp++; if (count !== 8'd0 || acc_out !== 40'd0 || ovf !== 1'b0 || acc_valid !== 1'b0) begin
      n_bad++; $display("FAIL clear_accept got cnt=%0d sum=%0d ovf=%b v=%b want 0/0/0/0", count, acc_out, ovf, acc_valid);
    end
    p_in = 32'sd3;
    p_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    p_valid = 1'b0;
    n_cmp++; if (acc_out !== 40'd24 || acc_valid !== 1'b1) begin n_bad++; $display("FAIL clear_next_block got sum=%0d v=%b want 24/1", acc_out, acc_valid); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (acc_valid !== 1'b0 || count !== 8'd0 || acc_out !== 40'd0) begin
      n_bad++; $display("FAIL clear_in_hold got v=%b cnt=%0d sum=%0d want 0/0/0", acc_valid, count, acc_out);
    end
  endtask

  task automatic test_async_reset();
    p_in = 32'sd4;
    p_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    p_valid = 1'b0;
    acc_ready = 1'b0;
    n_cmp++; if (acc_valid !== 1'b1 || acc_out !== 40'd32) begin n_bad++; $display("FAIL areset_pre got v=%b sum=%0d want 1/32", acc_valid, acc_out); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (acc_valid !== 1'b0 || acc_out !== 40'd0 || count !== 8'd0 || ovf !== 1'b0 || p_ready !== 1'b1) begin
      n_bad++; $display("FAIL areset_async got v=%b sum=%0d cnt=%0d ovf=%b rdy=%b want 0/0/0/0/1", acc_valid, acc_out, count, ovf, p_ready);
    end
    #2 rst = 1'b0;
    acc_ready = 1'b1;
    p_in = 32'sd9;
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    n_cmp++; if (count !== 8'd1 || acc_out !== 40'd9) begin n_bad++; $display("FAIL areset_first_accept got cnt=%0d sum=%0d want 1/9", count, acc_out); end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_negative();
    test_saturation();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 SHALL have parameter TAM, default 16: operand width of the upstream multiplier; products are 2*TAM bits.
REQ-002 SHALL have parameter GUARD, default 8: accumulator guard bits; ACCW = 2*TAM+GUARD.
REQ-003 SHALL have parameter LEN, default 8 (range 2..255): products summed per block.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 p_in  in  2*TAM signed  product from the multiplier (S output of the multiplier stage).
REQ-008 p_valid  in  1  p_in holds a valid product this cycle.
REQ-009 p_ready  out  1  block can accept a product this cycle.
REQ-010 clear  in  1  synchronous abort of the current block.
REQ-011 acc_out  out  ACCW signed  block sum, saturated.
REQ-012 acc_valid  out  1  acc_out holds a finished block sum.
REQ-013 acc_ready  in  1  consumer takes acc_out this cycle.
REQ-014 ovf  out  1  sticky saturation flag for the current or held block.
REQ-015 count  out  8  products accepted in the current block.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-017 A product SHALL be accepted exactly on cycles with p_valid=1 and p_ready=1.
REQ-018 p_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-019 IDLE -> ACCUM on the first accept; ACCUM -> HOLD on the LEN-th accept; HOLD -> IDLE on acc_valid=1 and acc_ready=1.
REQ-020 Each accept SHALL add sign-extended p_in to the internal sum and increment count.
REQ-021 Addition SHALL be computed in ACCW+1 bits; results above 2^(ACCW-1)-1 SHALL clamp to that value; results below -2^(ACCW-1) SHALL clamp to -2^(ACCW-1); any clamp SHALL set ovf.
REQ-022 Once saturated, the sum SHALL continue to accumulate from the clamped value.
REQ-023 acc_valid SHALL rise on the cycle after the LEN-th accept (one-cycle latency) and stay high, with acc_out, ovf and count stable, until the handshake completes.
REQ-024 In IDLE and ACCUM, acc_out SHALL show the running sum and acc_valid SHALL be 0.
REQ-025 After the HOLD handshake, the next cycle SHALL have sum=0, count=0, ovf=0, acc_valid=0, state IDLE.
REQ-026 clear=1 SHALL, on the next edge, force sum=0, count=0, ovf=0, acc_valid=0, state IDLE, in any state.
REQ-027 clear has priority over a simultaneous accept (the product is discarded) and over a simultaneous HOLD handshake.
REQ-028 p_valid while p_ready=0 SHALL have no effect; p_in is not captured.
REQ-029 count SHALL never exceed LEN and SHALL not wrap.

Reset
REQ-030 rst=1 SHALL immediately, without a clock, force state IDLE, sum=0, acc_out=0, acc_valid=0, ovf=0, count=0, p_ready=1.
REQ-031 Reset mid-block or in HOLD SHALL discard all partial and held results.
REQ-032 After rst is released, the first accept SHALL be possible on the first rising edge.

Verification
REQ-033 Defaults; 8 accepts of p_in=1 with acc_ready=1 -> acc_valid=1 one cycle after the 8th accept, acc_out=8, ovf=0, count=8; acc_valid low the cycle after.
REQ-034 8 accepts of p_in=32'hFFFFFFFF (-1) -> acc_out=40'hFFFFFFFFF8 (-8), ovf=0.
REQ-035 GUARD=1; 8 accepts of 32'h7FFFFFFF -> acc_out=33'h0FFFFFFFF (max), ovf=1; the next block starts with ovf=0.
REQ-036 Hold acc_ready=0 for 5 cycles after a block completes while driving p_valid=1 -> acc_out, acc_valid, count stable, p_ready=0, no product absorbed; acc_ready=1 -> IDLE next cycle.
REQ-037 After 3 accepts of 5, assert clear together with p_valid=1 and p_in=7 -> count=0, sum=0; the next full block sums only new products.
REQ-038 Assert rst asynchronously between edges while in HOLD -> all outputs reach their reset values before the next edge.
